// File: rtl/readrc_pkg.sv
// rtl/readrc_pkg.sv - Toeplitz seed defaults, default geometry and bit-reverse helper.
package readrc_pkg;

   localparam int BS_DEFAULT = 64;
   localparam int N_DEFAULT  = 256;
   localparam int L_DEFAULT  = 128;

   localparam logic [255:0] ROW0_DEFAULT =
      256'h38A50C80_9816771F_6507EFE5_CB6C8531_7B44DBD6_F0B1651D_840E8D92_4AD66FA2;
   localparam logic [127:0] COL0_DEFAULT =
      128'h02333460_5D2466C2_DE9725E2_70F0EE93;

   // Bit reverse of a default-width row, for the Toeplitz diagonal-shift logic.
   function automatic logic [N_DEFAULT-1:0] bitrev(input logic [N_DEFAULT-1:0] v);
      logic [N_DEFAULT-1:0] r;
      r = '0;
      for (int i = 0; i < N_DEFAULT; i++) begin
         r[i] = v[N_DEFAULT-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/seed_shreg.sv
// rtl/seed_shreg.sv - W-bit seed register with sync reset to INIT and BS-wide shift-load.
// Load path only exists when READRC_SEED_LOAD_EN is defined; otherwise the value is constant INIT.
module seed_shreg #(
   parameter int             W    = 256,
   parameter int             BS   = 64,
   parameter logic [W-1:0]   INIT = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [BS-1:0] ld_data,
   output logic [W-1:0]  q
);

   if (BS <= 0 || BS > W || (W % BS) != 0) begin : g_bad_geometry
      $fatal(1, "seed_shreg: W must be a positive multiple of BS");
   end

`ifdef READRC_SEED_LOAD_EN
   logic [W-1:0]    q_r = INIT;
   logic [W+BS-1:0] shifted;

   // New word enters at the LSB end; the oldest (MSB) word falls off.
   assign shifted = {q_r, ld_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= INIT;
      end else if (ld_valid) begin
         q_r <= shifted[W-1:0];
      end
   end

   assign q = q_r;
`else
   logic unused_ld;

   assign q         = INIT;
   assign unused_ld = ^{clk, reset, ld_valid, ld_data};
`endif

endmodule

// File: rtl/readrc_seed.sv
// rtl/readrc_seed.sv - Toeplitz hash seed (row0, col0, bit-reversed rrow0), valid from time zero.
// Optional in-field reload of BS-bit words when READRC_SEED_LOAD_EN is defined.
module readrc_seed
   import readrc_pkg::*;
#(
   parameter int           BS       = BS_DEFAULT,
   parameter int           N        = N_DEFAULT,
   parameter int           L        = L_DEFAULT,
   parameter logic [N-1:0] ROW_INIT = ROW0_DEFAULT[N-1:0],
   parameter logic [L-1:0] COL_INIT = COL0_DEFAULT[L-1:0]
) (
   input  logic          clk,
   input  logic          reset,
   output logic [N-1:0]  row0,
   output logic [N-1:0]  rrow0,
   output logic [L-1:0]  col0
`ifdef READRC_SEED_LOAD_EN
   ,
   input  logic          ld_valid,
   input  logic          ld_sel,
   input  logic [BS-1:0] ld_data
`endif
);

   if (BS <= 0) begin : g_bad_bs
      $fatal(1, "readrc_seed: BS must be positive");
   end else if ((N % BS) != 0 || (L % BS) != 0) begin : g_bad_multiple
      $fatal(1, "readrc_seed: N and L must be multiples of BS");
   end

   logic          row_ld;
   logic          col_ld;
   logic [BS-1:0] word;

`ifdef READRC_SEED_LOAD_EN
   assign row_ld = ld_valid & ~ld_sel;
   assign col_ld = ld_valid &  ld_sel;
   assign word   = ld_data;
`else
   assign row_ld = 1'b0;
   assign col_ld = 1'b0;
   assign word   = '0;
`endif

   seed_shreg #(
      .W    (N),
      .BS   (BS),
      .INIT (ROW_INIT)
   ) u_row (
      .clk      (clk),
      .reset    (reset),
      .ld_valid (row_ld),
      .ld_data  (word),
      .q        (row0)
   );

   seed_shreg #(
      .W    (L),
      .BS   (BS),
      .INIT (COL_INIT)
   ) u_col (
      .clk      (clk),
      .reset    (reset),
      .ld_valid (col_ld),
      .ld_data  (word),
      .q        (col0)
   );

   // Pure wiring so rrow0 follows row0 with no added latency.
   for (genvar i = 0; i < N; i++) begin : g_rev
      assign rrow0[i] = row0[N-1-i];
   end

endmodule

// File: tb/tb_readrc_seed.sv
// tb/tb_readrc_seed.sv - table-driven directed bench for readrc_seed (default and READRC_SEED_LOAD_EN builds).
module tb_readrc_seed;

   localparam logic [255:0] ROW_D =
      256'h38A50C80_9816771F_6507EFE5_CB6C8531_7B44DBD6_F0B1651D_840E8D92_4AD66FA2;
   localparam logic [127:0] COL_D =
      128'h02333460_5D2466C2_DE9725E2_70F0EE93;
   localparam logic [127:0] ROW_SMALL = 128'h7B44DBD6_F0B1651D_840E8D92_4AD66FA2;
   localparam logic [63:0]  COL_SMALL = 64'hDE9725E2_70F0EE93;

   logic         clk;
   logic         reset;
   logic         ld_valid;
   logic         ld_sel;
   logic [63:0]  ld_data;
   logic [255:0] row0;
   logic [255:0] rrow0;
   logic [127:0] col0;
   logic [127:0] s_row0;
   logic [127:0] s_rrow0;
   logic [63:0]  s_col0;

   int checks;
   int errors;

   readrc_seed u_dut (
      .clk      (clk),
      .reset    (reset),
      .row0     (row0),
      .rrow0    (rrow0),
      .col0     (col0)
`ifdef READRC_SEED_LOAD_EN
      ,
      .ld_valid (ld_valid),
      .ld_sel   (ld_sel),
      .ld_data  (ld_data)
`endif
   );

   readrc_seed #(
      .BS (32),
      .N  (128),
      .L  (64)
   ) u_small (
      .clk      (clk),
      .reset    (reset),
      .row0     (s_row0),
      .rrow0    (s_rrow0),
      .col0     (s_col0)
`ifdef READRC_SEED_LOAD_EN
      ,
      .ld_valid (1'b0),
      .ld_sel   (1'b0),
      .ld_data  (32'h0)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         rst;
      logic         v;
      logic         sel;
      logic [63:0]  d;
      logic [255:0] row;
      logic [127:0] col;
   } vec_t;

   function automatic logic [255:0] rev256(input logic [255:0] v);
      logic [255:0] r;
      for (int i = 0; i < 256; i++) r[i] = v[255-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t t);
      reset    = t.rst;
      ld_valid = t.v;
      ld_sel   = t.sel;
      ld_data  = t.d;
      @(posedge clk);
      #1;
      check({tag, " row0"},  row0,            t.row);
      check({tag, " col0"},  {128'h0, col0},  {128'h0, t.col});
      check({tag, " rrow0"}, rrow0,           rev256(t.row));
   endtask

   vec_t rtab[14];
`ifdef READRC_SEED_LOAD_EN
   vec_t ltab[11];
`endif

   initial begin
      logic [255:0] rd;
      logic [127:0] cd;
      logic [255:0] rr;
      logic [63:0]  a, b, c, dd;

      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      ld_valid = 1'b0;
      ld_sel   = 1'b0;
      ld_data  = '0;
      rd = ROW_D;
      cd = COL_D;
      a  = 64'h0123456789ABCDEF;
      b  = 64'hFEDCBA9876543210;
      c  = 64'h5555AAAA0F0F3C3C;
      dd = 64'hFFFFFFFFFFFFFFFF;

      // Power-up values, before any clock edge and with reset asserted.
      #1;
      rr = rrow0;
      check("t0 row0", row0, ROW_D);
      check("t0 col0", {128'h0, col0}, {128'h0, COL_D});
      check("t0 rrow0 hi", {224'h0, rr[255:224]}, {224'h0, 32'h45F66B52});
      check("t0 rrow0 lo", {224'h0, rr[31:0]}, {224'h0, 32'h0130A51C});
      check("t0 rrow0 full", rrow0, rev256(ROW_D));
      check("t0 small row0", {128'h0, s_row0}, {128'h0, ROW_SMALL});
      check("t0 small col0", {192'h0, s_col0}, {192'h0, COL_SMALL});

      // Reset held, 10 free-running cycles, a reset pulse, then free running again.
      for (int i = 0; i < 14; i++) begin
         rtab[i] = '{rst: (i == 0 || i == 11), v: 1'b0, sel: 1'b0, d: 64'h0, row: ROW_D, col: COL_D};
      end
      for (int i = 0; i < 14; i++) run_vec($sformatf("rst%0d", i), rtab[i]);

`ifdef READRC_SEED_LOAD_EN
      ltab[0]  = '{1'b0, 1'b1, 1'b0, 64'h1, {rd[191:0], 64'h1}, cd};
      ltab[1]  = '{1'b0, 1'b1, 1'b1, a,     {rd[191:0], 64'h1}, {cd[63:0], a}};
      ltab[2]  = '{1'b0, 1'b1, 1'b1, b,     {rd[191:0], 64'h1}, {a, b}};
      ltab[3]  = '{1'b0, 1'b0, 1'b1, c,     {rd[191:0], 64'h1}, {a, b}};
      ltab[4]  = '{1'b1, 1'b1, 1'b0, b,     rd, cd};
      ltab[5]  = '{1'b0, 1'b1, 1'b1, a,     rd, {cd[63:0], a}};
      ltab[6]  = '{1'b1, 1'b0, 1'b1, b,     rd, cd};
      ltab[7]  = '{1'b0, 1'b1, 1'b0, a,     {rd[191:0], a}, cd};
      ltab[8]  = '{1'b0, 1'b1, 1'b0, b,     {rd[127:0], a, b}, cd};
      ltab[9]  = '{1'b0, 1'b1, 1'b0, c,     {rd[63:0], a, b, c}, cd};
      ltab[10] = '{1'b0, 1'b1, 1'b0, dd,    {a, b, c, dd}, cd};
      for (int i = 0; i < 11; i++) run_vec($sformatf("ld%0d", i), ltab[i]);

      // Mid-reload reset on the column: one word in, then reset drops it.
      reset = 1'b0; ld_valid = 1'b1; ld_sel = 1'b1; ld_data = b;
      @(posedge clk); #1;
      check("mid col partial", {128'h0, col0}, {128'h0, cd[63:0], b});
      reset = 1'b1; ld_valid = 1'b0;
      @(posedge clk); #1;
      check("mid col reset", {128'h0, col0}, {128'h0, COL_D});
      check("mid row reset", row0, ROW_D);
      reset = 1'b0;
      @(posedge clk); #1;
      check("small row hold", {128'h0, s_row0}, {128'h0, ROW_SMALL});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/readrc_seed.md
Name: readrc_seed

Overview:
- Holds the Toeplitz-hash seed: first row (row0) and first column (col0) of the Toeplitz matrix used by the hashing datapath.
- Also supplies the bit-reversed first row (rrow0) so downstream diagonal-shift logic can index it directly.
- The seed comes from hard-wired defaults and is valid from time zero.
- An optional in-field reload interface exists, loading BS-bit words.

Parameters:
- BS, 64, block/word size in bits; reload granularity; N and L must be multiples of BS.
- N, 256, row length (bits of row0/rrow0).
- L, 128, column length (bits of col0).
- ROW_INIT, low N bits of readrc_pkg::ROW0_DEFAULT, power-up/reset value of row0.
- COL_INIT, low L bits of readrc_pkg::COL0_DEFAULT, power-up/reset value of col0.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- row0  output  N  first row of Toeplitz matrix.
- rrow0  output  N  bit-reversed row0.
- col0  output  L  first column of Toeplitz matrix.
- ld_valid  input  1  reload strobe (only with SEED_LOAD_EN).
- ld_sel  input  1  0=row, 1=col (only with SEED_LOAD_EN).
- ld_data  input  BS  reload word (only with SEED_LOAD_EN).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- row0 and col0 are registers whose declared initial value equals ROW_INIT/COL_INIT.
- Outputs are correct at simulation time 0, before any clock edge and while reset is asserted.
- Any rising clk with reset=1 reloads ROW_INIT/COL_INIT. Reset has priority over ld_valid.
- rrow0 is purely combinational: rrow0[i] = row0[N-1-i] for all i. It has zero latency relative to row0.
- Defaults for N=256: ROW0_DEFAULT = 256'h38A50C80_9816771F_6507EFE5_CB6C8531_7B44DBD6_F0B1651D_840E8D92_4AD66FA2.
- Defaults for L=128: COL0_DEFAULT = 128'h02333460_5D2466C2_DE9725E2_70F0EE93.
- Elaboration-time check: BS>0, N%BS==0 and L%BS==0, otherwise $fatal.
- Without SEED_LOAD_EN, row0/col0 never change after power-up; reset is then a no-op reload of the same values.

Optional Feature:
- Macro: READRC_SEED_LOAD_EN.
- Defined: adds ld_valid, ld_sel and ld_data.
  - On a rising clk with reset=0 and ld_valid=1, the selected register shifts left by BS and ld_data enters the LSB word: reg <= {reg[W-1-BS:0], ld_data}.
  - The MSB word is discarded.
  - N/BS (row) or L/BS (col) consecutive loads fully replace the seed. The first word loaded ends up in the MSBs.
  - rrow0 tracks the new row0 in the same cycle the register updates.
  - ld_valid=0 holds the registers.
  - A reset mid-reload restores the defaults and discards any partial load.
- Undefined: these ports do not exist and the registers are constant.

Decomposition:
- Package readrc_pkg holds:
  - ROW0_DEFAULT (256 bits) and COL0_DEFAULT (128 bits);
  - the default BS/N/L localparams;
  - function bitrev(N-bit) for reuse by the Toeplitz datapath.
- One natural sub-module, seed_shreg #(W, BS, INIT): a W-bit register with initial value, sync reset to INIT and BS-wide shift-load. It is instantiated twice (row W=N, column W=L).

Test Plan:
- Time 0, reset=1, no clock edge yet -> row0==ROW0_DEFAULT, col0==COL0_DEFAULT.
- Check rrow0 at time 0 -> rrow0[255:224]==32'h45F66B52, rrow0[31:0]==32'h0130A51C, and rrow0[i]==row0[255-i] for all i.
- Reset pulse after 10 free-running cycles -> outputs unchanged; equal defaults in every cycle.
- Seed reload (SEED_LOAD_EN), ld_sel=0, load 64'h1 once:
  - row0 == {ROW0_DEFAULT[191:0], 64'h1};
  - col0 unchanged;
  - rrow0 == bitrev(new row0) in the same cycle.
- Seed reload (SEED_LOAD_EN), ld_sel=1, two loads A,B:
  - after both loads, col0=={A,B};
  - assert reset after the first load only -> col0==COL0_DEFAULT next cycle.
- Overrides N=128, L=64, BS=32 -> row0==ROW0_DEFAULT[127:0], col0==COL0_DEFAULT[63:0]; BS=48 with N=128 -> elaboration $fatal.
